rf_access_arbiter: RTL and testbench
====================================

RF_ACCESS_ARBITER -- requirements
Module: rf_access_arbiter

Interface
REQ-001 SHALL have: clk  in  1  sole clock, all flops on rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: cpu_rd_req in 1 (operand-read request); cpu_rs1_adr, cpu_rs2_adr in 5 (source registers); cpu_rd_done out 1 (operands valid pulse); rs1_data, rs2_data out 32.
REQ-004 SHALL have: wb_we in 1, wb_adr in 5, wb_data in 32 (writeback write).
REQ-005 SHALL have: mon_req in 1, mon_we in 1, mon_adr in 5, mon_wdata in 32 (monitor access); mon_ack out 1; mon_rdata out 32.
REQ-006 SHALL have: ram_radr out 5, ram_rdata in 32 (synchronous RAM, data one cycle after address); ram_wadr out 5, ram_wdata out 32, ram_wen out 1.

Function
REQ-007 Read FSM SHALL have states IDLE, C_RS1, C_RS2, C_FIN, M_RD, M_FIN.
REQ-008 In IDLE, cpu_rd_req SHALL latch both addresses, next state C_RS1; monitor read request (mon_req & ~mon_we) SHALL latch mon_adr, next state M_RD.
REQ-009 IDLE conflict: CPU wins unless streak counter equals 2, then monitor wins.
REQ-010 Streak counter (2 bits) SHALL increment on each CPU grant while a monitor read is pending, and clear on a monitor grant or when no monitor read is pending.
REQ-011 ram_radr SHALL be rs1 in C_RS1, rs2 in C_RS2, mon_adr in M_RD, 0 otherwise.
REQ-012 rs1_data SHALL capture at end of C_RS2, rs2_data at end of C_FIN, mon_rdata at end of M_FIN.
REQ-013 Address 0 SHALL capture 32'd0 regardless of RAM contents.
REQ-014 Bypass: if ram_wen & ram_wadr==ram_radr (nonzero) in the address cycle, the capture SHALL use that cycle's ram_wdata instead of ram_rdata.
REQ-015 C_FIN and M_FIN SHALL go to IDLE; cpu_rd_done (after C_FIN) or mon_ack (after M_FIN) SHALL pulse exactly one cycle in that IDLE cycle.
REQ-016 A new request SHALL be acceptable in the same IDLE cycle that done/ack pulses (back-to-back, 4-cycle CPU period).
REQ-017 Sequences SHALL not abort; cpu_rd_req or mon_req dropping mid-sequence SHALL not change completion or the pulse.
REQ-018 Write port: wb_we SHALL have absolute priority; ram_wen/ram_wadr/ram_wdata SHALL take wb_* when wb_we=1.
REQ-019 Monitor write (mon_req & mon_we) SHALL issue only in a cycle with wb_we=0 and no mon_ack pulsing, holding until granted.
REQ-020 A granted monitor write SHALL produce mon_ack one cycle later; write to address 0 SHALL suppress ram_wen but still ack.
REQ-021 Writeback to address 0 SHALL suppress ram_wen.
REQ-022 Monitor handshake: requester holds mon_req/mon_we/mon_adr/mon_wdata stable until mon_ack; mon_req seen in the ack cycle is a new request.
REQ-023 Monitor read and monitor write acks SHALL never coincide; pending writes wait while the FSM is in M_RD/M_FIN.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, streak 0, rs1_data, rs2_data, mon_rdata 0, cpu_rd_done, mon_ack, ram_wen 0, ram_radr 0.
REQ-025 Reset mid-sequence SHALL discard it with no done/ack pulse after release.

Structure
REQ-026 Package rf_arb_pkg SHALL hold FSM state encodings, XLEN=32, RADR_W=5, STREAK_MAX=2.
REQ-027 Write-port priority/x0 suppression SHALL be sub-module rf_wr_mux; read FSM stays in top.

Verification
REQ-028 x1=0x11,x2=0x22; cpu_rd_req rs1=1,rs2=2 at cycle 0 -> C_RS1..C_FIN cycles 1-3, done cycle 4, rs1_data=0x11, rs2_data=0x22.
REQ-029 Read rs1=0,rs2=5 with x0 RAM word 0xDEAD -> rs1_data=0, rs2_data=x5.
REQ-030 wb_we x2=0x55 in C_RS2 cycle -> rs2_data=0x55 (bypass).
REQ-031 cpu_rd_req held high plus monitor read of x3 -> two CPU sequences then monitor granted; mon_ack with mon_rdata=x3.
REQ-032 Monitor write x4=0x99 with wb_we high 3 cycles -> ram_wen for monitor in cycle 3, mon_ack cycle 4, later read of x4=0x99.
REQ-033 rst_n pulsed during C_RS2 -> all outputs 0, no cpu_rd_done after release.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file access arbiter.
//   XLEN       : data word width
//   RADR_W     : register address width
//   STREAK_W   : width of the CPU-win streak counter
//   STREAK_MAX : CPU grants in a row before a waiting monitor read wins
//   rd_state_e : read-port FSM states
package rf_arb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned RADR_W     = 5;
  localparam int unsigned STREAK_W   = 2;
  localparam int unsigned STREAK_MAX = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    C_RS1 = 3'd1,
    C_RS2 = 3'd2,
    C_FIN = 3'd3,
    M_RD  = 3'd4,
    M_FIN = 3'd5
  } rd_state_e;

endpackage

// File: rtl/rf_wr_mux.sv
// Write-port selector for the register-file RAM.
// Writeback always wins; a monitor write is granted only when writeback is
// idle. Writes to x0 are dropped (ram_wen low) but a monitor write to x0 is
// still granted so that it gets acknowledged.
//   en           : global enable (low forces ram_wen and grant low)
//   wb_*         : writeback write request
//   mon_wr_req   : eligible monitor write request
//   mon_adr/...  : monitor write address and data
//   ram_w*       : RAM write port
//   mon_wr_grant : monitor write issued this cycle
module rf_wr_mux
  import rf_arb_pkg::*;
(
  input  logic              en,
  input  logic              wb_we,
  input  logic [RADR_W-1:0] wb_adr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              mon_wr_req,
  input  logic [RADR_W-1:0] mon_adr,
  input  logic [XLEN-1:0]   mon_wdata,
  output logic              ram_wen,
  output logic [RADR_W-1:0] ram_wadr,
  output logic [XLEN-1:0]   ram_wdata,
  output logic              mon_wr_grant
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave a signal unassigned and infer a latch.
    ram_wen      = 1'b0;
    ram_wadr     = '0;
    ram_wdata    = '0;
    mon_wr_grant = 1'b0;
    if (wb_we) begin
      ram_wadr  = wb_adr;
      ram_wdata = wb_data;
      ram_wen   = en & (wb_adr != '0);
    end else if (mon_wr_req) begin
      mon_wr_grant = en;
      ram_wadr     = mon_adr;
      ram_wdata    = mon_wdata;
      ram_wen      = en & (mon_adr != '0);
    end
  end

endmodule

// File: rtl/rf_access_arbiter.sv
// Arbitrates one synchronous register-file RAM between CPU operand reads,
// writeback writes and a debug monitor (reads and writes).
//   clk, rst_n          : clock, async active-low reset
//   cpu_rd_req/rs*_adr  : operand read request; cpu_rd_done pulses with
//                         rs1_data/rs2_data valid
//   wb_we/wb_adr/wb_data: writeback write (highest priority)
//   mon_*               : monitor request; mon_ack pulses when done,
//                         mon_rdata valid for reads
//   ram_*               : RAM ports (read data one cycle after address)
module rf_access_arbiter
  import rf_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd_req,
  input  logic [RADR_W-1:0] cpu_rs1_adr,
  input  logic [RADR_W-1:0] cpu_rs2_adr,
  output logic              cpu_rd_done,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              wb_we,
  input  logic [RADR_W-1:0] wb_adr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              mon_req,
  input  logic              mon_we,
  input  logic [RADR_W-1:0] mon_adr,
  input  logic [XLEN-1:0]   mon_wdata,
  output logic              mon_ack,
  output logic [XLEN-1:0]   mon_rdata,
  output logic [RADR_W-1:0] ram_radr,
  input  logic [XLEN-1:0]   ram_rdata,
  output logic [RADR_W-1:0] ram_wadr,
  output logic [XLEN-1:0]   ram_wdata,
  output logic              ram_wen
);

  rd_state_e           state_q, state_d;
  logic [RADR_W-1:0]   rs1_q, rs2_q, madr_q;
  logic [STREAK_W-1:0] streak_q;
  logic                byp_hit_q;
  logic [XLEN-1:0]     byp_data_q;
  logic [XLEN-1:0]     cap_data;
  logic                cpu_grant, mon_rd_grant;
  logic                mon_rd_pend, mon_wr_req, mon_wr_grant;

  assign mon_rd_pend = mon_req & ~mon_we;

  // Monitor writes stay off the cycle where any ack pulses, and wait out a
  // monitor read so the two kinds of ack can never land together.
  assign mon_wr_req = mon_req & mon_we & ~mon_ack &
                      (state_q != M_RD) & (state_q != M_FIN);

  rf_wr_mux u_wr_mux (
    .en           (rst_n),
    .wb_we        (wb_we),
    .wb_adr       (wb_adr),
    .wb_data      (wb_data),
    .mon_wr_req   (mon_wr_req),
    .mon_adr      (mon_adr),
    .mon_wdata    (mon_wdata),
    .ram_wen      (ram_wen),
    .ram_wadr     (ram_wadr),
    .ram_wdata    (ram_wdata),
    .mon_wr_grant (mon_wr_grant)
  );

  always_comb begin
    state_d      = state_q;
    cpu_grant    = 1'b0;
    mon_rd_grant = 1'b0;
    ram_radr     = '0;
    case (state_q)
      IDLE: begin
        // CPU wins ties until it has won STREAK_MAX times over a waiting
        // monitor read.
        if (cpu_rd_req &&
            !(mon_rd_pend && streak_q == STREAK_W'(STREAK_MAX))) begin
          cpu_grant = 1'b1;
          state_d   = C_RS1;
        end else if (mon_rd_pend) begin
          mon_rd_grant = 1'b1;
          state_d      = M_RD;
        end
      end
      C_RS1: begin
        ram_radr = rs1_q;
        state_d  = C_RS2;
      end
      C_RS2: begin
        ram_radr = rs2_q;
        state_d  = C_FIN;
      end
      C_FIN:   state_d = IDLE;
      M_RD: begin
        ram_radr = madr_q;
        state_d  = M_FIN;
      end
      M_FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Data for the word addressed last cycle: x0 reads as zero, and a write to
  // the same register in the address cycle overrides the stale RAM word.
  assign cap_data = byp_hit_q ? byp_data_q : ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      madr_q      <= '0;
      byp_hit_q   <= 1'b0;
      byp_data_q  <= '0;
      rs1_data    <= '0;
      rs2_data    <= '0;
      mon_rdata   <= '0;
      cpu_rd_done <= 1'b0;
      mon_ack     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;

      if (mon_rd_grant || !mon_rd_pend) streak_q <= '0;
      else if (cpu_grant)               streak_q <= streak_q + STREAK_W'(1);

      if (cpu_grant) begin
        rs1_q <= cpu_rs1_adr;
        rs2_q <= cpu_rs2_adr;
      end
      if (mon_rd_grant) madr_q <= mon_adr;

      byp_hit_q  <= (ram_radr == '0) | (ram_wen & (ram_wadr == ram_radr));
      byp_data_q <= (ram_radr == '0) ? '0 : ram_wdata;

      if (state_q == C_RS2) rs1_data  <= cap_data;
      if (state_q == C_FIN) rs2_data  <= cap_data;
      if (state_q == M_FIN) mon_rdata <= cap_data;

      cpu_rd_done <= (state_q == C_FIN);
      mon_ack     <= (state_q == M_FIN) | mon_wr_grant;
    end
  end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter: a behavioural synchronous RAM, a
// table of CPU read vectors with optional writeback in a chosen cycle, and
// hand-written sequences for arbitration, monitor write and reset.
module tb_rf_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_rd_req;
  logic [4:0]  cpu_rs1_adr, cpu_rs2_adr;
  logic        cpu_rd_done;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_we;
  logic [4:0]  wb_adr;
  logic [31:0] wb_data;
  logic        mon_req, mon_we;
  logic [4:0]  mon_adr;
  logic [31:0] mon_wdata;
  logic        mon_ack;
  logic [31:0] mon_rdata;
  logic [4:0]  ram_radr, ram_wadr;
  logic [31:0] ram_rdata, ram_wdata;
  logic        ram_wen;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  // Synchronous RAM, read-before-write on a same-address collision.
  always @(posedge clk) begin
    if (ram_wen) mem[ram_wadr] <= ram_wdata;
    ram_rdata <= mem[ram_radr];
  end

  rf_access_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_rd_req  (cpu_rd_req),
    .cpu_rs1_adr (cpu_rs1_adr),
    .cpu_rs2_adr (cpu_rs2_adr),
    .cpu_rd_done (cpu_rd_done),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .wb_we       (wb_we),
    .wb_adr      (wb_adr),
    .wb_data     (wb_data),
    .mon_req     (mon_req),
    .mon_we      (mon_we),
    .mon_adr     (mon_adr),
    .mon_wdata   (mon_wdata),
    .mon_ack     (mon_ack),
    .mon_rdata   (mon_rdata),
    .ram_radr    (ram_radr),
    .ram_rdata   (ram_rdata),
    .ram_wadr    (ram_wadr),
    .ram_wdata   (ram_wdata),
    .ram_wen     (ram_wen)
  );

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    int          wb_cyc;   // 0 = no writeback, else cycle 1..3 of the read
    logic [4:0]  wb_adr;
    logic [31:0] wb_data;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One CPU read issued in cycle 0; done expected in cycle 4.
  task automatic run_read(input string tag, input logic [4:0] rs1,
                          input logic [4:0] rs2, input int wb_cyc,
                          input logic [4:0] wadr, input logic [31:0] wdat,
                          input logic [31:0] exp1, input logic [31:0] exp2);
    @(posedge clk); #1;
    cpu_rd_req = 1'b1; cpu_rs1_adr = rs1; cpu_rs2_adr = rs2; wb_we = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      cpu_rd_req = 1'b0;
      wb_we      = (wb_cyc == c);
      wb_adr     = wadr;
      wb_data    = wdat;
      @(negedge clk);
      check($sformatf("%s done c%0d", tag, c), 32'(cpu_rd_done), 32'(c == 4));
      if (c == 1) check($sformatf("%s radr rs1", tag), 32'(ram_radr), 32'(rs1));
      if (c == 2) check($sformatf("%s radr rs2", tag), 32'(ram_radr), 32'(rs2));
      if (c == wb_cyc)
        check($sformatf("%s ram_wen", tag), 32'(ram_wen), 32'(wadr != 5'd0));
      if (c == 4) begin
        check($sformatf("%s rs1_data", tag), rs1_data, exp1);
        check($sformatf("%s rs2_data", tag), rs2_data, exp2);
      end
    end
    @(posedge clk); #1;
    wb_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);
    mem[0] = 32'hDEAD; mem[1] = 32'h11; mem[2] = 32'h22; mem[3] = 32'h33;

    //          rs1    rs2    wbc wadr   wdata          exp1           exp2
    vecs[0] = '{5'd1,  5'd2,  0,  5'd0,  32'h0,         32'h11,        32'h22};
    vecs[1] = '{5'd0,  5'd5,  0,  5'd0,  32'h0,         32'h0,         32'h105};
    vecs[2] = '{5'd1,  5'd2,  2,  5'd2,  32'h55,        32'h11,        32'h55};
    vecs[3] = '{5'd2,  5'd6,  1,  5'd6,  32'h66,        32'h55,        32'h66};
    vecs[4] = '{5'd7,  5'd7,  1,  5'd7,  32'h77,        32'h77,        32'h77};
    vecs[5] = '{5'd0,  5'd0,  2,  5'd0,  32'hBAD,       32'h0,         32'h0};
    vecs[6] = '{5'd8,  5'd9,  3,  5'd9,  32'h99,        32'h108,       32'h109};
    vecs[7] = '{5'd9,  5'd31, 0,  5'd0,  32'h0,         32'h99,        32'h11F};
    vecs[8] = '{5'd0,  5'd3,  1,  5'd0,  32'h1234,      32'h0,         32'h33};

    // Reset state, with write and read requests active during reset.
    rst_n = 1'b0;
    cpu_rd_req = 1'b1; cpu_rs1_adr = 5'd1; cpu_rs2_adr = 5'd2;
    wb_we = 1'b1; wb_adr = 5'd3; wb_data = 32'hFFFF;
    mon_req = 1'b0; mon_we = 1'b0; mon_adr = '0; mon_wdata = '0;
    #22;
    check("rst ram_wen", 32'(ram_wen), 32'd0);
    check("rst ram_radr", 32'(ram_radr), 32'd0);
    check("rst done", 32'(cpu_rd_done), 32'd0);
    check("rst ack", 32'(mon_ack), 32'd0);
    check("rst rs1_data", rs1_data, 32'd0);
    check("rst rs2_data", rs2_data, 32'd0);
    check("rst mon_rdata", mon_rdata, 32'd0);
    cpu_rd_req = 1'b0; wb_we = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_read($sformatf("v%0d", i), vecs[i].rs1, vecs[i].rs2, vecs[i].wb_cyc,
               vecs[i].wb_adr, vecs[i].wb_data, vecs[i].exp1, vecs[i].exp2);

    // CPU held high against a monitor read of x3: two CPU sequences
    // back-to-back, then the monitor wins on the third IDLE decision.
    @(posedge clk); #1;
    cpu_rd_req = 1'b1; cpu_rs1_adr = 5'd1; cpu_rs2_adr = 5'd3;
    mon_req = 1'b1; mon_we = 1'b0; mon_adr = 5'd3;
    @(negedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (c == 11) begin
        cpu_rd_req = 1'b0; mon_req = 1'b0;
      end
      @(negedge clk);
      check($sformatf("arb done c%0d", c), 32'(cpu_rd_done),
            32'(c == 4 || c == 8));
      check($sformatf("arb ack c%0d", c), 32'(mon_ack), 32'(c == 11));
      if (c == 4) begin
        check("arb rs1_data", rs1_data, 32'h11);
        check("arb rs2_data", rs2_data, 32'h33);
      end
      if (c == 9)  check("arb mon radr", 32'(ram_radr), 32'd3);
      if (c == 11) check("arb mon_rdata", mon_rdata, 32'h33);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("arb ack drop", 32'(mon_ack), 32'd0);

    // Monitor write x4=0x99 blocked by writeback for three cycles.
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk); #1;
      wb_we = (c <= 2); wb_adr = 5'd10; wb_data = 32'hA0A;
      mon_req = (c <= 4); mon_we = 1'b1; mon_adr = 5'd4; mon_wdata = 32'h99;
      @(negedge clk);
      if (c <= 2) begin
        check($sformatf("mw wb wen c%0d", c), 32'(ram_wen), 32'd1);
        check($sformatf("mw wb wadr c%0d", c), 32'(ram_wadr), 32'd10);
      end
      if (c == 3) begin
        check("mw mon wen", 32'(ram_wen), 32'd1);
        check("mw mon wadr", 32'(ram_wadr), 32'd4);
        check("mw mon wdata", ram_wdata, 32'h99);
      end
      if (c == 4) check("mw wen in ack", 32'(ram_wen), 32'd0);
      check($sformatf("mw ack c%0d", c), 32'(mon_ack), 32'(c == 4));
    end
    mon_req = 1'b0; mon_we = 1'b0;
    run_read("mw rd", 5'd4, 5'd10, 0, 5'd0, 32'h0, 32'h99, 32'hA0A);

    // Monitor write to x0: no RAM write, ack still pulses.
    @(posedge clk); #1;
    mon_req = 1'b1; mon_we = 1'b1; mon_adr = 5'd0; mon_wdata = 32'h5;
    @(negedge clk);
    check("mw0 wen", 32'(ram_wen), 32'd0);
    check("mw0 ack early", 32'(mon_ack), 32'd0);
    @(posedge clk); #1;
    mon_req = 1'b0; mon_we = 1'b0;
    @(negedge clk);
    check("mw0 ack", 32'(mon_ack), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("mw0 ack drop", 32'(mon_ack), 32'd0);

    // Reset pulsed during C_RS2 discards the read.
    @(posedge clk); #1;
    cpu_rd_req = 1'b1; cpu_rs1_adr = 5'd1; cpu_rs2_adr = 5'd2;
    @(posedge clk); #1;
    cpu_rd_req = 1'b0;
    @(posedge clk); #1;
    #1;
    check("mid radr", 32'(ram_radr), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid rst radr", 32'(ram_radr), 32'd0);
    check("mid rst rs1_data", rs1_data, 32'd0);
    check("mid rst rs2_data", rs2_data, 32'd0);
    check("mid rst mon_rdata", mon_rdata, 32'd0);
    check("mid rst done", 32'(cpu_rd_done), 32'd0);
    check("mid rst ack", 32'(mon_ack), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("mid no done c%0d", c), 32'(cpu_rd_done), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
